ex_hazard_ctrl: RTL and testbench

- Pipeline controller that sequences the EX stage datapath.
- Tracks in-flight destination registers in EX, MEM and WB with an internal scoreboard shift register.
- Drives the EX operand-forwarding selects, load-use stalls and taken-branch flushes.
- Sits beside the IF/ID and ID/EX pipeline registers; consumes branch_taken from the EX stage.

---
 rtl/ex_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: in-flight destination scoreboard, load-use stalls,
// taken-branch flushes and registered operand-forwarding selects (EX_FORWARD_EN).
module ex_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic                  bubble_id_ex,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } slot_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  slot_t ex_reg, mem_reg, wb_reg, ex_next;

  logic ex_m1, ex_m2, mem_m1, mem_m2;
  logic hazard, stall, flush, bubble, advance;

  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  // x0 is hardwired zero, so it never produces a dependency.
  function automatic logic slot_match(input slot_t s, input logic [REG_ADDR_W-1:0] rs,
                                      input logic uses);
    return s.valid && s.reg_write && (s.rd == rs) && (rs != '0) && uses;
  endfunction

  always_comb begin
    ex_m1  = slot_match(ex_reg,  id_rs1, id_uses_rs1);
    ex_m2  = slot_match(ex_reg,  id_rs2, id_uses_rs2);
    mem_m1 = slot_match(mem_reg, id_rs1, id_uses_rs1);
    mem_m2 = slot_match(mem_reg, id_rs2, id_uses_rs2);
`ifdef EX_FORWARD_EN
    hazard = id_valid && ex_reg.mem_read && (ex_m1 || ex_m2);
`else
    hazard = id_valid && (ex_m1 || ex_m2 || mem_m1 || mem_m2);
`endif
    // The branch in EX is older than the ID instruction, so the flush wins.
    flush   = ex_branch_taken && !rst;
    stall   = hazard && !flush && !rst;
    bubble  = stall || flush;
    advance = id_valid && !bubble;

    ex_next = '0;
    if (advance) begin
      ex_next.valid     = 1'b1;
      ex_next.rd        = id_rd;
      ex_next.reg_write = id_reg_write;
      ex_next.mem_read  = id_mem_read;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_reg        <= '0;
      mem_reg       <= '0;
      wb_reg        <= '0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      wb_reg  <= mem_reg;
      mem_reg <= ex_reg;
      ex_reg  <= ex_next;
      if (stall) stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (flush) flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

`ifdef EX_FORWARD_EN
  logic [1:0] fwd_a_reg, fwd_b_reg;

  // Selects are captured as the instruction enters EX: today's EX producer
  // sits in MEM next cycle, today's MEM producer sits in WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a_reg <= FWD_RF;
      fwd_b_reg <= FWD_RF;
    end else if (advance) begin
      fwd_a_reg <= ex_m1 ? FWD_MEM : (mem_m1 ? FWD_WB : FWD_RF);
      fwd_b_reg <= ex_m2 ? FWD_MEM : (mem_m2 ? FWD_WB : FWD_RF);
    end else begin
      fwd_a_reg <= FWD_RF;
      fwd_b_reg <= FWD_RF;
    end
  end

  assign fwd_a = fwd_a_reg;
  assign fwd_b = fwd_b_reg;
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

  assign stall_if_id  = stall;
  assign flush_if_id  = flush;
  assign bubble_id_ex = bubble;
  assign stall_cnt    = stall_cnt_reg;
  assign flush_cnt    = flush_cnt_reg;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: directed instruction sequences push
// expected per-cycle outputs; a monitor pops and compares each cycle.
module tb_ex_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic        id_reg_write = 1'b0, id_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic        stall_if_id, flush_if_id, bubble_id_ex;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] sc_exp = 0;
  logic [31:0] fc_exp = 0;

  typedef struct {
    string       name;
    logic        stall, flush, bubble;
    logic [1:0]  fa, fb;
    logic [31:0] sc, fc;
  } exp_t;

  exp_t exp_q[$];

  ex_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .stall_if_id(stall_if_id),
    .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s got %0d expected %0d", name, field, act, expv);
    end
  endtask

  // Monitor: one comparison set per cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("txn %-16s stall=%0d flush=%0d bubble=%0d fwd_a=%b fwd_b=%b stall_cnt=%0d flush_cnt=%0d",
                 e.name, stall_if_id, flush_if_id, bubble_id_ex, fwd_a, fwd_b, stall_cnt, flush_cnt);
        chk(e.name, "stall_if_id",  32'(stall_if_id),  32'(e.stall));
        chk(e.name, "flush_if_id",  32'(flush_if_id),  32'(e.flush));
        chk(e.name, "bubble_id_ex", 32'(bubble_id_ex), 32'(e.bubble));
        chk(e.name, "fwd_a",        32'(fwd_a),        32'(e.fa));
        chk(e.name, "fwd_b",        32'(fwd_b),        32'(e.fb));
        chk(e.name, "stall_cnt",    stall_cnt,         e.sc);
        chk(e.name, "flush_cnt",    flush_cnt,         e.fc);
      end
    end
  end

  // One cycle of ID-stage stimulus plus the hand-derived response for that cycle.
  task automatic drive(input string name, input logic r, input logic v,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic rw,
                       input logic mr, input logic br, input logic es, input logic ef,
                       input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_rd = rd; id_rs1 = rs1; id_uses_rs1 = u1;
    id_rs2 = rs2; id_uses_rs2 = u2; id_reg_write = rw; id_mem_read = mr;
    ex_branch_taken = br;
    if (r) begin
      sc_exp = 0;
      fc_exp = 0;
    end
    e.name = name; e.stall = es; e.flush = ef; e.bubble = es | ef;
    e.fa = fa; e.fb = fb; e.sc = sc_exp; e.fc = fc_exp;
    exp_q.push_back(e);
    if (!r && es) sc_exp = sc_exp + 1;
    if (!r && ef) fc_exp = fc_exp + 1;
  endtask

  task automatic alu(input string name, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic es, input logic [1:0] fa,
                     input logic [1:0] fb);
    drive(name, 1'b0, 1'b1, rd, rs1, 1'b1, rs2, 1'b1, 1'b1, 1'b0, 1'b0, es, 1'b0, fa, fb);
  endtask

  task automatic ld(input string name, input logic [4:0] rd, input logic [4:0] rs1);
    drive(name, 1'b0, 1'b1, rd, rs1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
          2'b00, 2'b00);
  endtask

  task automatic nop(input string name, input logic [1:0] fa, input logic [1:0] fb);
    drive(name, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
          fa, fb);
  endtask

  task automatic drain();
    nop("drain", 2'b00, 2'b00);
    nop("drain", 2'b00, 2'b00);
  endtask

  initial begin
    drive("reset0", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
          1'b0, 1'b0, 2'b00, 2'b00);
    drive("reset1", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
          1'b0, 1'b0, 2'b00, 2'b00);
    nop("idle", 2'b00, 2'b00);

    // ALU chain: add x5,x1,x2 ; add x6,x5,x1
    alu("t1_add_x5", 5'd5, 5'd1, 5'd2, 1'b0, 2'b00, 2'b00);
`ifdef EX_FORWARD_EN
    alu("t1_add_x6", 5'd6, 5'd5, 5'd1, 1'b0, 2'b00, 2'b00);
    nop("t1_ex", 2'b10, 2'b00);
`else
    alu("t1_add_x6_s1", 5'd6, 5'd5, 5'd1, 1'b1, 2'b00, 2'b00);
    alu("t1_add_x6_s2", 5'd6, 5'd5, 5'd1, 1'b1, 2'b00, 2'b00);
    alu("t1_add_x6", 5'd6, 5'd5, 5'd1, 1'b0, 2'b00, 2'b00);
    nop("t1_ex", 2'b00, 2'b00);
`endif
    drain();

    // Distance 2: add x5 ; nop ; sub x7,x1,x5
    alu("t2_add_x5", 5'd5, 5'd1, 5'd2, 1'b0, 2'b00, 2'b00);
    nop("t2_gap", 2'b00, 2'b00);
`ifdef EX_FORWARD_EN
    alu("t2_sub_x7", 5'd7, 5'd1, 5'd5, 1'b0, 2'b00, 2'b00);
    nop("t2_ex", 2'b00, 2'b01);
`else
    alu("t2_sub_x7_s", 5'd7, 5'd1, 5'd5, 1'b1, 2'b00, 2'b00);
    alu("t2_sub_x7", 5'd7, 5'd1, 5'd5, 1'b0, 2'b00, 2'b00);
    nop("t2_ex", 2'b00, 2'b00);
`endif
    drain();

    // Load-use: ld x8 ; add x9,x8,x8
    ld("t3_ld_x8", 5'd8, 5'd1);
    alu("t3_add_x9_s1", 5'd9, 5'd8, 5'd8, 1'b1, 2'b00, 2'b00);
`ifdef EX_FORWARD_EN
    alu("t3_add_x9", 5'd9, 5'd8, 5'd8, 1'b0, 2'b00, 2'b00);
    nop("t3_ex", 2'b01, 2'b01);
`else
    alu("t3_add_x9_s2", 5'd9, 5'd8, 5'd8, 1'b1, 2'b00, 2'b00);
    alu("t3_add_x9", 5'd9, 5'd8, 5'd8, 1'b0, 2'b00, 2'b00);
    nop("t3_ex", 2'b00, 2'b00);
`endif
    drain();

    // Taken branch while ID holds a load-use consumer: flush wins
    ld("t4_ld_x10", 5'd10, 5'd1);
    drive("t4_br_hazard", 1'b0, 1'b1, 5'd11, 5'd10, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0,
          1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
    nop("t4_after", 2'b00, 2'b00);
    drain();

    // x0 destination: ld x0 ; add x1,x0,x0
    ld("t5_ld_x0", 5'd0, 5'd1);
    alu("t5_add_x1", 5'd1, 5'd0, 5'd0, 1'b0, 2'b00, 2'b00);
    nop("t5_ex", 2'b00, 2'b00);
    drain();

    // Operand not read: rs2 names the producer but uses_rs2=0
    alu("t6_add_x12", 5'd12, 5'd1, 5'd2, 1'b0, 2'b00, 2'b00);
    drive("t6_nouse", 1'b0, 1'b1, 5'd13, 5'd3, 1'b1, 5'd12, 1'b0, 1'b1, 1'b0,
          1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    nop("t6_ex", 2'b00, 2'b00);
    drain();

    // Youngest producer wins: two writers of x20, then a reader of x20
    alu("t8_add_x20a", 5'd20, 5'd1, 5'd2, 1'b0, 2'b00, 2'b00);
    alu("t8_add_x20b", 5'd20, 5'd3, 5'd4, 1'b0, 2'b00, 2'b00);
`ifdef EX_FORWARD_EN
    alu("t8_add_x21", 5'd21, 5'd20, 5'd20, 1'b0, 2'b00, 2'b00);
    nop("t8_ex", 2'b10, 2'b10);
`else
    alu("t8_add_x21_s1", 5'd21, 5'd20, 5'd20, 1'b1, 2'b00, 2'b00);
    alu("t8_add_x21_s2", 5'd21, 5'd20, 5'd20, 1'b1, 2'b00, 2'b00);
    alu("t8_add_x21", 5'd21, 5'd20, 5'd20, 1'b0, 2'b00, 2'b00);
    nop("t8_ex", 2'b00, 2'b00);
`endif
    drain();

    // Reset while a load-use hazard is presented: everything clears at once
    ld("t7_ld_x14", 5'd14, 5'd1);
    drive("t7_rst_stall", 1'b1, 1'b1, 5'd15, 5'd14, 1'b1, 5'd14, 1'b1, 1'b1, 1'b0,
          1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    drive("t7_post_rst", 1'b0, 1'b1, 5'd15, 5'd14, 1'b1, 5'd14, 1'b1, 1'b1, 1'b0,
          1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    nop("t7_end", 2'b00, 2'b00);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
